// File: rtl/seq_pkg.sv
// Shared definitions for the 0,2,5,8,11,14 sequence checker: legal values,
// FSM state encoding and the successor function.
package seq_pkg;

    localparam logic [3:0] SEQ_S0 = 4'd0;
    localparam logic [3:0] SEQ_S1 = 4'd2;
    localparam logic [3:0] SEQ_S2 = 4'd5;
    localparam logic [3:0] SEQ_S3 = 4'd8;
    localparam logic [3:0] SEQ_S4 = 4'd11;
    localparam logic [3:0] SEQ_S5 = 4'd14;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] next;
    } seq_step_t;

    // Successor of v in the sequence; legal=0 (next=0) for off-sequence values.
    function automatic seq_step_t seq_next(input logic [3:0] v);
        seq_step_t r;
        r.legal = 1'b1;
        r.next  = SEQ_S0;
        case (v)
            SEQ_S0:  r.next = SEQ_S1;
            SEQ_S1:  r.next = SEQ_S2;
            SEQ_S2:  r.next = SEQ_S3;
            SEQ_S3:  r.next = SEQ_S4;
            SEQ_S4:  r.next = SEQ_S5;
            SEQ_S5:  r.next = SEQ_S0;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_next_lut.sv
// Combinational successor lookup used on the LOCKED compare path.
module seq_next_lut
    import seq_pkg::*;
(
    input  logic [3:0] value,
    output logic       legal,
    output logic [3:0] next_value
);

    seq_step_t step;

    assign step       = seq_next(value);
    assign legal      = step.legal;
    assign next_value = step.next;

endmodule

// File: rtl/sequence_checker.sv
// Locks onto the 0,2,5,8,11,14 counter stream, flags mismatches and keeps
// saturating error and completed-period counts. All outputs are registered.
module sequence_checker
    import seq_pkg::*;
#(
    parameter int ERR_W = 8,
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_value,
    input  logic             in_valid,
    input  logic             clr_stats,
    output logic             locked,
    output logic [3:0]       expected,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [PER_W-1:0] period_count
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       expected_q, expected_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [PER_W-1:0] period_count_q, period_count_d;

    logic             lut_legal;
    logic [3:0]       lut_next;
    logic             match;
    logic             mismatch;
    logic             period_done;

    seq_next_lut u_next_lut (
        .value      (in_value),
        .legal      (lut_legal),
        .next_value (lut_next)
    );

    assign match = lut_legal && (in_value == expected_q);

    // NOTE: non-blocking assignments for every registered signal, so all
    // flops update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= HUNT;
            expected_q     <= 4'd0;
            err_pulse_q    <= 1'b0;
            err_count_q    <= '0;
            period_count_q <= '0;
        end else begin
            state_q        <= state_d;
            expected_q     <= expected_d;
            err_pulse_q    <= err_pulse_d;
            err_count_q    <= err_count_d;
            period_count_q <= period_count_d;
        end
    end

    // NOTE: every signal gets a hold/default value before the case so no
    // path through this block leaves it unassigned (no inferred latch).
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        mismatch    = 1'b0;
        period_done = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_value == SEQ_S0) state_d = ARMED;
                end
                ARMED: begin
                    if (in_value == SEQ_S1) begin
                        state_d    = LOCKED;
                        expected_d = SEQ_S2;
                    end else if (in_value != SEQ_S0) begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        expected_d  = lut_next;
                        period_done = (in_value == SEQ_S5);
                    end else begin
                        mismatch   = 1'b1;
                        expected_d = 4'd0;
                        state_d    = (in_value == SEQ_S0) ? ARMED : HUNT;
                    end
                end
                default: begin
                    state_d    = HUNT;
                    expected_d = 4'd0;
                end
            endcase
        end
    end

    // Statistics: clear wins over a same-cycle increment; both saturate.
    always_comb begin
        err_pulse_d    = mismatch;
        err_count_d    = err_count_q;
        period_count_d = period_count_q;
        if (clr_stats) begin
            err_count_d    = '0;
            period_count_d = '0;
        end else begin
            if (mismatch && err_count_q != ERR_MAX)
                err_count_d = err_count_q + 1'b1;
            if (period_done && period_count_q != PER_MAX)
                period_count_d = period_count_q + 1'b1;
        end
    end

    assign locked       = (state_q == LOCKED);
    assign expected     = expected_q;
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_count_q;
    assign period_count = period_count_q;

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
- Downstream monitor for the specific-sequence counter, which emits the repeating sequence 0, 2, 5, 8, 11, 14, 0, ...
- Samples the counter's 4-bit output and locks onto the sequence.
- Once locked, checks every valid sample against the expected next value.
- Reports lock status, single-cycle error pulses, a saturating error count and a saturating count of completed periods.

Parameters:
- ERR_W, 8, width of err_count (saturates at 2^ERR_W-1)
- PER_W, 8, width of period_count (saturates at 2^PER_W-1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_value  input  4  sample from the sequence counter output
- in_valid  input  1  sample qualifier; tie high when the counter free-runs
- clr_stats  input  1  synchronous clear of err_count and period_count
- locked  output  1  high while in LOCKED
- expected  output  4  value expected at the next valid sample (0 when not LOCKED)
- err_pulse  output  1  one-cycle pulse on mismatch while LOCKED
- err_count  output  ERR_W  saturating mismatch count
- period_count  output  PER_W  saturating count of completed 0..14 periods

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high. While rst is sampled high, all state and outputs clear on that edge: state=HUNT, locked=0, expected=0, err_pulse=0, err_count=0, period_count=0.
- Legal sequence: 0→2→5→8→11→14→0.
  - next(v) is defined only for these six values.
  - Any other 4-bit value is illegal.
- Registered outputs: every output is registered. Responses appear one cycle after the edge that samples the input.
- in_valid=0: the sample is ignored.
  - State, expected and counters hold.
  - err_pulse drops to 0 on that edge.
- State machine, evaluated on each valid sample:
  - HUNT:
    - in_value==0 → ARMED.
    - Otherwise stay in HUNT.
    - No errors are counted.
  - ARMED:
    - in_value==2 → LOCKED, expected=5.
    - in_value==0 → stay in ARMED. This tolerates the duplicated 0 the counter emits immediately after its reset.
    - Any other value → HUNT, no error.
  - LOCKED, in_value==expected:
    - expected=next(in_value).
    - If in_value==14, period_count increments (saturating).
  - LOCKED, in_value!=expected:
    - err_pulse=1 for one cycle.
    - err_count increments (saturating).
    - locked=0, expected=0.
    - Next state is ARMED if in_value==0, otherwise HUNT. This gives immediate relock when the source restarts from 0.
- clr_stats=1 clears err_count and period_count on that edge.
  - It has priority over a same-cycle increment: the result is 0, not 1.
  - It does not affect state, locked, expected or err_pulse.
- rst dominates clr_stats and in_valid.
- Saturation: counters stop at the all-ones value. err_pulse still fires on every mismatch.
- Reset mid-period: the checker returns to HUNT. It relocks only after a fresh 0,2 pair.

Decomposition:
- Package seq_pkg contains:
  - localparams SEQ_S0..SEQ_S5 = 0,2,5,8,11,14.
  - State encoding HUNT=2'd0, ARMED=2'd1, LOCKED=2'd2.
  - A function seq_next(v) returning the successor value, plus a legal flag.
- One sub-module: seq_next_lut, a combinational 4-bit → {legal, next[3:0]} lookup used by the LOCKED compare path.
- The top module holds the FSM and the counters.

Test Plan:
- Reset stream: rst high 2 cycles, then in_valid=1 and in_value 0,0,2,5,8,11,14,0,2 → locked rises the cycle after the 2 is sampled; expected sequence 5,8,11,14,0,2,5; period_count=1 after the 14; err_count=0.
- Injected error: while LOCKED expecting 8, drive 9 → err_pulse high exactly 1 cycle, err_count=1, locked=0, state HUNT; feeding 0,2 relocks with expected=5.
- Error on 0: while LOCKED expecting 11, drive 0 then 2 → err_count=1, locked=1 again after the 2 with no second error.
- Valid gaps: insert in_valid=0 cycles (in_value=7) between legal samples → no errors, expected holds across the gaps, period_count still increments once per period.
- Saturation and clear:
  - With ERR_W=2, force 5 mismatches → err_count sticks at 3 and err_pulse fires 5 times.
  - Assert clr_stats in the same cycle as a mismatch → err_count=0.
- Reset mid-operation: assert rst while locked with expected=11 → next cycle locked=0, expected=0, both counters 0; a stream resuming at 11 does not lock or count errors.
